// File: rtl/weight_loader_pkg.sv
// Shared types and default geometry for the weight RAM loader.
// The state enum is exported so checkers can bind to the loader's state register.
package weight_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 128;
   localparam int COUNT_W    = 8;

endpackage

// File: rtl/weight_ram_loader_checksum_acc.sv
// Modulo-2**DATA_W byte accumulator with synchronous clear.
// Used for both the load-side sum and the read-back sum.
module checksum_acc
   import weight_loader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              add_en,
   input  logic [DATA_W-1:0] byte_in,
   output logic [DATA_W-1:0] sum
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (add_en) begin
         sum <= sum + byte_in;
      end
   end

endmodule

// File: rtl/weight_ram_loader.sv
// Streams count weight bytes into a RAM starting at base_addr, then reads them
// back and compares the read-back sum against the load sum.
module weight_ram_loader
   import weight_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [COUNT_W-1:0] count,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               ram_we,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [DATA_W-1:0]  ram_din,
   input  logic [DATA_W-1:0]  ram_dout,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [DATA_W-1:0]  checksum
);

   localparam logic [COUNT_W:0] DEPTH_L = (COUNT_W+1)'(DEPTH);

   // Handshake: a beat transfers on every clock edge where in_valid and in_ready
   // are both high; in_ready never depends on in_valid, and in_valid may drop at
   // any time without losing state.

   state_t               state;
   logic [ADDR_W-1:0]    base_q;
   logic [COUNT_W-1:0]   cnt_q;
   logic [COUNT_W-1:0]   acc_cnt;
   logic [COUNT_W-1:0]   vcnt;
   logic [DATA_W-1:0]    ver_sum;
   logic [DATA_W-1:0]    ver_sum_next;
   logic                 beat;
   logic                 start_ok;
   logic                 count_too_big;
   logic                 ver_add;

   assign beat          = (state == ST_LOAD) && in_valid && in_ready;
   assign start_ok      = (state == ST_IDLE) && start;
   assign count_too_big = {1'b0, count} > DEPTH_L;
   // Read data lags its address by one cycle, so the first VERIFY cycle adds nothing.
   assign ver_add       = (state == ST_VERIFY) && (vcnt != '0);
   assign ver_sum_next  = ver_sum + ram_dout;

   checksum_acc #(.DATA_W(DATA_W)) u_load_sum (
      .clk     (clk),
      .reset   (reset),
      .clear   (start_ok),
      .add_en  (beat),
      .byte_in (in_data),
      .sum     (checksum)
   );

   checksum_acc #(.DATA_W(DATA_W)) u_verify_sum (
      .clk     (clk),
      .reset   (reset),
      .clear   (start_ok),
      .add_en  (ver_add),
      .byte_in (ram_dout),
      .sum     (ver_sum)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         base_q   <= '0;
         cnt_q    <= '0;
         acc_cnt  <= '0;
         vcnt     <= '0;
         in_ready <= 1'b0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_q  <= base_addr;
                  cnt_q   <= count;
                  acc_cnt <= '0;
                  vcnt    <= '0;
                  busy    <= 1'b1;
                  if (count == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     err   <= 1'b0;
                  end else if (count_too_big) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state    <= ST_LOAD;
                     in_ready <= 1'b1;
                     err      <= 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               if (beat) begin
                  ram_we   <= 1'b1;
                  ram_addr <= base_q + ADDR_W'(acc_cnt);
                  ram_din  <= in_data;
                  acc_cnt  <= acc_cnt + 1'b1;
                  if (acc_cnt == cnt_q - 1'b1) in_ready <= 1'b0;
               end else if (!in_ready) begin
                  // Final write is on the bus this cycle; present the first read address next.
                  state    <= ST_VERIFY;
                  ram_addr <= base_q;
               end
            end
            ST_VERIFY: begin
               vcnt <= vcnt + 1'b1;
               if ((vcnt + 1'b1) < cnt_q) ram_addr <= base_q + ADDR_W'(vcnt + 1'b1);
               if (vcnt == cnt_q) begin
                  err   <= (ver_sum_next != checksum);
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_ram_loader.sv
// Bench for weight_ram_loader: behavioural RAM, per-scenario tasks, and a
// write scoreboard keyed by {cycle, address, data}.
module tb_weight_ram_loader;

   localparam int AW   = 7;
   localparam int DW   = 8;
   localparam int SB_W = 16 + AW + DW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [7:0]    count = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;
   logic          busy;
   logic          done;
   logic          err;
   logic [DW-1:0] checksum;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [SB_W-1:0] exp_q[$];
   logic [SB_W-1:0] obs_q[$];
   logic [DW-1:0]   job_bytes [0:255];
   logic [DW-1:0]   mem [0:127];
   logic            corrupt_en = 1'b0;

   weight_ram_loader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .checksum  (checksum)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: synchronous write, one-cycle read latency, optional corruption of 0x03
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= (corrupt_en && ram_addr == 7'h03) ? ~ram_din : ram_din;
      ram_dout <= mem[ram_addr];
   end

   // driver: issues one job, pushes expected writes per accepted beat, records observed writes
   task automatic run_job(input logic [AW-1:0] base, input logic [7:0] cnt, input bit toggle,
                          input bit hold_start, input int abort_at, output int lat,
                          output logic err_v, output logic [DW-1:0] cs_v,
                          output int proto_bad, output bit timed_out);
      int s_edge, bi, limit;
      bit phase, seen_done;
      bi = 0; phase = 1'b1; proto_bad = 0; timed_out = 1'b0; seen_done = 1'b0;
      lat = -1; err_v = 1'bx; cs_v = 'x;
      limit = 2 * int'(cnt) + 40;
      @(negedge clk);
      start = 1'b1; base_addr = base; count = cnt; s_edge = cyc + 1;
      for (int k = 0; k < limit && !seen_done; k++) begin
         @(negedge clk);
         if (hold_start) begin
            base_addr = 7'h40; count = 8'd5;
         end else begin
            start = 1'b0;
         end
         if (ram_we) obs_q.push_back({16'(cyc), ram_addr, ram_din});
         if (!busy) proto_bad++;
         if (done) begin
            seen_done = 1'b1; lat = cyc - s_edge; err_v = err; cs_v = checksum;
            start = 1'b0; in_valid = 1'b0;
         end else if (abort_at >= 0 && bi == abort_at) begin
            in_valid = 1'b0;
            return;
         end else begin
            if (in_ready && bi >= int'(cnt)) proto_bad++;
            in_valid = toggle ? phase : (bi < int'(cnt));
            phase = ~phase;
            in_data = job_bytes[bi & 255];
            if (in_ready && in_valid && bi < int'(cnt)) begin
               exp_q.push_back({16'(cyc + 1), AW'(base + AW'(bi)), job_bytes[bi]});
               bi++;
            end
         end
      end
      if (!seen_done) timed_out = 1'b1;
      else begin
         @(negedge clk);
         if (done || busy) proto_bad++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({in_ready, ram_we, busy, done, err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags got %b expected 00000", {in_ready, ram_we, busy, done, err});
      end
      vectors++;
      if ({ram_addr, ram_din, checksum} !== '0) begin
         miscompares++;
         $display("FAIL reset_buses got addr=%h din=%h cs=%h expected zeros", ram_addr, ram_din, checksum);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset got busy=%b in_ready=%b expected 0 0", busy, in_ready);
      end
   endtask

   task automatic test_basic_load();
      int lat, pb; bit to; logic e_v; logic [DW-1:0] cs, exp_cs; logic [SB_W-1:0] e, o;
      exp_cs = '0;
      for (int i = 0; i < 16; i++) begin
         job_bytes[i] = DW'(i + 1);
         exp_cs = exp_cs + DW'(i + 1);
      end
      // start held high for the whole job with changing base/count: must be ignored
      run_job(7'h00, 8'd16, 1'b0, 1'b1, -1, lat, e_v, cs, pb, to);
      vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout got timeout expected done"); end
      // LOAD 16 beats + 1 drain cycle + VERIFY 17 cycles, then done
      vectors++; if (lat != 34) begin miscompares++; $display("FAIL basic_latency got %0d expected 34", lat); end
      vectors++; if (cs !== exp_cs || exp_cs !== 8'h88) begin miscompares++; $display("FAIL basic_checksum got %h expected 88", cs); end
      vectors++; if (e_v !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b expected 0", e_v); end
      vectors++; if (pb != 0) begin miscompares++; $display("FAIL basic_protocol got %0d violations expected 0", pb); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL basic_write got none expected %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL basic_write got %h expected %h", o, e); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL basic_extra_writes got %0d expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_wrap();
      int lat, pb; bit to; logic e_v; logic [DW-1:0] cs; logic [SB_W-1:0] e, o;
      job_bytes[0] = 8'hAA; job_bytes[1] = 8'hBB; job_bytes[2] = 8'hCC; job_bytes[3] = 8'hDD;
      run_job(7'h7E, 8'd4, 1'b0, 1'b0, -1, lat, e_v, cs, pb, to);
      vectors++; if (to || lat != 10) begin miscompares++; $display("FAIL wrap_latency got %0d expected 10", lat); end
      vectors++; if (cs !== 8'h0E) begin miscompares++; $display("FAIL wrap_checksum got %h expected 0e", cs); end
      vectors++; if (e_v !== 1'b0) begin miscompares++; $display("FAIL wrap_err got %b expected 0", e_v); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL wrap_write got none expected %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL wrap_write got %h expected %h", o, e); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL wrap_extra_writes got %0d expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_zero_and_overflow();
      int lat, pb; bit to; logic e_v; logic [DW-1:0] cs;
      run_job(7'h10, 8'd0, 1'b0, 1'b0, -1, lat, e_v, cs, pb, to);
      vectors++; if (to || lat != 0) begin miscompares++; $display("FAIL zero_latency got %0d expected 0", lat); end
      vectors++; if (e_v !== 1'b0 || cs !== 8'h00) begin miscompares++; $display("FAIL zero_status got err=%b cs=%h expected 0 00", e_v, cs); end
      vectors++; if (obs_q.size() != 0 || pb != 0) begin miscompares++; $display("FAIL zero_writes got %0d writes %0d violations expected 0 0", obs_q.size(), pb); obs_q.delete(); end
      run_job(7'h10, 8'd200, 1'b0, 1'b0, -1, lat, e_v, cs, pb, to);
      vectors++; if (to || lat != 0) begin miscompares++; $display("FAIL over_latency got %0d expected 0", lat); end
      vectors++; if (e_v !== 1'b1) begin miscompares++; $display("FAIL over_err got %b expected 1", e_v); end
      vectors++; if (obs_q.size() != 0 || pb != 0) begin miscompares++; $display("FAIL over_writes got %0d writes %0d violations expected 0 0", obs_q.size(), pb); obs_q.delete(); end
      exp_q.delete();
   endtask

   task automatic test_stall();
      int lat, pb; bit to; logic e_v; logic [DW-1:0] cs, exp_cs; logic [SB_W-1:0] e, o;
      exp_cs = '0;
      for (int i = 0; i < 8; i++) begin
         job_bytes[i] = DW'($urandom_range(0, 255));
         exp_cs = exp_cs + job_bytes[i];
      end
      run_job(7'h20, 8'd8, 1'b1, 1'b0, -1, lat, e_v, cs, pb, to);
      vectors++; if (to) begin miscompares++; $display("FAIL stall_timeout got timeout expected done"); end
      vectors++; if (cs !== exp_cs) begin miscompares++; $display("FAIL stall_checksum got %h expected %h", cs, exp_cs); end
      vectors++; if (e_v !== 1'b0 || pb != 0) begin miscompares++; $display("FAIL stall_status got err=%b viol=%0d expected 0 0", e_v, pb); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL stall_write got none expected %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL stall_write got %h expected %h", o, e); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL stall_extra_writes got %0d expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_verify_error();
      int lat, pb; bit to; logic e_v; logic [DW-1:0] cs, exp_cs;
      exp_cs = '0;
      for (int i = 0; i < 8; i++) begin
         job_bytes[i] = DW'($urandom_range(0, 255));
         exp_cs = exp_cs + job_bytes[i];
      end
      corrupt_en = 1'b1;
      run_job(7'h00, 8'd8, 1'b0, 1'b0, -1, lat, e_v, cs, pb, to);
      corrupt_en = 1'b0;
      vectors++; if (to || lat != 18) begin miscompares++; $display("FAIL verr_latency got %0d expected 18", lat); end
      vectors++; if (e_v !== 1'b1) begin miscompares++; $display("FAIL verr_err got %b expected 1", e_v); end
      vectors++; if (cs !== exp_cs) begin miscompares++; $display("FAIL verr_checksum got %h expected %h", cs, exp_cs); end
      repeat (3) @(negedge clk);
      vectors++; if (err !== 1'b1 || checksum !== exp_cs) begin miscompares++; $display("FAIL verr_hold got err=%b cs=%h expected 1 %h", err, checksum, exp_cs); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_load();
      int lat, pb; bit to; logic e_v; logic [DW-1:0] cs, exp_cs; logic [SB_W-1:0] e, o;
      for (int i = 0; i < 10; i++) job_bytes[i] = DW'($urandom_range(0, 255));
      run_job(7'h50, 8'd10, 1'b0, 1'b0, 5, lat, e_v, cs, pb, to);
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL abort_midload got in_ready=%b busy=%b expected 1 1", in_ready, busy); end
      reset = 1'b0;
      #1;
      vectors++;
      if ({in_ready, ram_we, busy, done, err} !== 5'b0 || {ram_addr, ram_din, checksum} !== '0) begin
         miscompares++;
         $display("FAIL abort_reset got rdy=%b we=%b busy=%b done=%b err=%b addr=%h din=%h cs=%h expected zeros",
                  in_ready, ram_we, busy, done, err, ram_addr, ram_din, checksum);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL abort_write got none expected %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL abort_write got %h expected %h", o, e); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL abort_extra_writes got %0d expected 0", obs_q.size()); obs_q.delete(); end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (mem[7'h50 + i] !== job_bytes[i]) begin miscompares++; $display("FAIL abort_ram_kept[%0d] got %h expected %h", i, mem[7'h50 + i], job_bytes[i]); end
      end
      @(negedge clk);
      reset = 1'b1;
      job_bytes[0] = DW'($urandom_range(0, 255));
      job_bytes[1] = DW'($urandom_range(0, 255));
      exp_cs = job_bytes[0] + job_bytes[1];
      run_job(7'h10, 8'd2, 1'b0, 1'b0, -1, lat, e_v, cs, pb, to);
      vectors++; if (to || lat != 6) begin miscompares++; $display("FAIL after_abort_latency got %0d expected 6", lat); end
      vectors++; if (cs !== exp_cs || e_v !== 1'b0) begin miscompares++; $display("FAIL after_abort_status got cs=%h err=%b expected %h 0", cs, e_v, exp_cs); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL after_abort_write got none expected %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL after_abort_write got %h expected %h", o, e); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL after_abort_extra got %0d expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_back_to_back();
      int lat, pb, n; bit to; logic e_v; logic [DW-1:0] cs, exp_cs; logic [AW-1:0] b;
      logic [SB_W-1:0] e, o;
      for (int j = 0; j < 3; j++) begin
         n = $urandom_range(1, 20);
         b = AW'($urandom_range(0, 127));
         exp_cs = '0;
         for (int i = 0; i < n; i++) begin
            job_bytes[i] = DW'($urandom_range(0, 255));
            exp_cs = exp_cs + job_bytes[i];
         end
         run_job(b, 8'(n), 1'b0, 1'b0, -1, lat, e_v, cs, pb, to);
         vectors++; if (to || lat != 2 * n + 2) begin miscompares++; $display("FAIL b2b_latency[%0d] got %0d expected %0d", j, lat, 2 * n + 2); end
         vectors++; if (cs !== exp_cs || e_v !== 1'b0 || pb != 0) begin miscompares++; $display("FAIL b2b_status[%0d] got cs=%h err=%b viol=%0d expected %h 0 0", j, cs, e_v, pb, exp_cs); end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL b2b_write got none expected %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL b2b_write got %h expected %h", o, e); end end
         end
         vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL b2b_extra_writes got %0d expected 0", obs_q.size()); obs_q.delete(); end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      for (int i = 0; i < 256; i++) job_bytes[i] = '0;
      test_reset();
      test_basic_load();
      test_wrap();
      test_zero_and_overflow();
      test_stall();
      test_verify_error();
      test_reset_mid_load();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
